dma_wb_arbiter: RTL
===================

DMA_WB_ARBITER -- requirements
Module: dma_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of Wishbone master requesters sharing the bridge's 64-bit Wishbone slave port.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles a strobed access may wait for ack/rty/err.
REQ-003 wb_clk_i  in  1  sole clock, rising edge.
REQ-004 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 m_cyc_i, m_stb_i, m_we_i, m_cab_i, m_pref_i  in  NREQ each  per-requester Wishbone controls; bit n is requester n.
REQ-006 m_adr_i, m_dat_i, m_dat64_i  in  32*NREQ each  per-requester address, low data and high data, packed so requester n occupies [32n+31:32n].
REQ-007 m_sel_i  in  4*NREQ  per-requester byte selects.
REQ-008 m_ack_o, m_rty_o, m_err_o  out  NREQ each  per-requester termination.
REQ-009 m_dat_o, m_dat64_o  out  32 each  read data broadcast to all requesters.
REQ-010 wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_pref_o  out  1 each  shared port to the bridge.
REQ-011 wbm_adr_o, wbm_dat_o, wbm_dat64_o  out  32 each  shared port to the bridge.
REQ-012 wbm_sel_o  out  4  shared port to the bridge.
REQ-013 wbm_ack_i, wbm_rty_i, wbm_err_i  in  1 each  bridge terminations.
REQ-014 wbm_dat_i, wbm_dat64_i  in  32 each  bridge read data.
REQ-015 gnt_o  out  NREQ  one-hot current grant, all-zero when no grant.
REQ-016 timeout_o  out  1  one-cycle pulse when the watchdog fires.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, BUSY and TOERR.
REQ-018 IDLE: if any m_cyc_i bit is set, the arbiter SHALL register a grant to the first set bit searched round-robin from last_gnt+1 (mod NREQ) and enter BUSY; request-to-wbm_cyc_o latency is 1 cycle.
REQ-019 BUSY: the wbm_* outputs SHALL combinationally mirror the granted requester's inputs; non-granted requesters SHALL see m_ack_o, m_rty_o and m_err_o at 0.
REQ-020 BUSY: wbm_ack_i, wbm_rty_i and wbm_err_i SHALL route combinationally to the granted bit only; m_dat_o and m_dat64_o SHALL equal wbm_dat_i and wbm_dat64_i at all times.
REQ-021 BUSY to IDLE: when the granted m_cyc_i is low, the arbiter SHALL update last_gnt to the granted index and clear gnt_o; wbm_cyc_o SHALL be 0 for at least one cycle between grants.
REQ-022 Retry: on wbm_rty_i, the arbiter SHALL pass the retry, force BUSY to IDLE and update last_gnt, so that other pending requesters win next.
REQ-023 Watchdog: a counter SHALL increment each BUSY cycle with wbm_stb_o=1 and no termination; it SHALL clear on any termination, on stb low and on leaving BUSY.
REQ-024 When the watchdog counter reaches TIMEOUT, the FSM SHALL enter TOERR.
REQ-025 TOERR (one cycle): wbm_cyc_o and wbm_stb_o SHALL be 0, m_err_o SHALL be 1 on the granted bit and timeout_o SHALL be 1; the FSM SHALL then go to IDLE and update last_gnt.
REQ-026 Simultaneous termination and timeout in the same cycle: the termination SHALL take precedence and TOERR SHALL NOT be entered.
REQ-027 A granted requester that drops and raises m_cyc_i in adjacent cycles SHALL re-arbitrate; it SHALL receive no priority boost.
REQ-028 When not in BUSY, all wbm_* controls SHALL be 0, and wbm_adr_o, wbm_dat_o and wbm_sel_o SHALL be 0.

Reset
REQ-029 While wb_rst_i is high, asynchronously: state=IDLE, gnt_o=0, last_gnt=NREQ-1 (requester 0 wins first), watchdog=0, timeout_o=0, all wbm_* and m_ack_o/m_rty_o/m_err_o at 0.
REQ-030 Reset asserted mid-transfer SHALL drop wbm_cyc_o immediately, with no termination reported to any requester.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE, BUSY, TOERR) and the default NREQ and TIMEOUT constants.
REQ-032 The round-robin priority search SHALL be a separate combinational sub-module, rr_pick (inputs: request vector, last index; output: one-hot winner plus valid).
REQ-033 Watchdog width SHALL be clog2(TIMEOUT+1).

Verification
REQ-034 Single requester: reset; m_cyc_i=001 with 4-beat cab write and ack every cycle -> wbm_cyc_o high 1 cycle later, 4 m_ack_o[0] pulses, gnt_o=001 then 000.
REQ-035 Contention: m_cyc_i=111 held, each releases after 1 ack -> grant order 0,1,2,0 with exactly one idle cycle between grants.
REQ-036 Retry fairness: req0 granted, wbm_rty_i=1 while m_cyc_i=011 -> m_rty_o=01, next grant is requester 1.
REQ-037 Timeout: TIMEOUT=8, req2 strobes with no response -> TOERR after 8 stalled cycles, m_err_o=100 and timeout_o for 1 cycle, then IDLE.
REQ-038 Ack on the timeout cycle -> m_ack_o delivered, no m_err_o, no timeout_o.
REQ-039 Reset mid-burst after 2 acks -> wbm_cyc_o=0 asynchronously, gnt_o=000, and requester 0 wins first after release.

Source files
------------

// File: rtl/dma_wb_arbiter_pkg.sv
// Shared types and defaults for the DMA Wishbone arbiter: FSM encoding,
// default requester count / watchdog limit, and the muxed request payload.
package dma_wb_arbiter_pkg;

  localparam int unsigned NREQ_DEFAULT    = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned AW              = 32;
  localparam int unsigned DW              = 32;
  localparam int unsigned SW              = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_TOERR = 2'd2
  } state_e;

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic          cab;
    logic          pref;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [DW-1:0] dat64;
    logic [SW-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/dma_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searched from
// last_i+1 upward (mod NREQ); returns a one-hot winner and a valid flag.
module rr_pick
  import dma_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  int unsigned idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_i) + k) % NREQ;
      if (!valid_o && req_i[IW'(idx)]) begin
        gnt_o[IW'(idx)] = 1'b1;
        valid_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_wb_arbiter.sv
// Round-robin arbiter sharing one 64-bit Wishbone slave port among NREQ
// masters, with a per-access watchdog that terminates stalled strobes.
module dma_wb_arbiter
  import dma_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NREQ-1:0]    m_cyc_i,
  input  logic [NREQ-1:0]    m_stb_i,
  input  logic [NREQ-1:0]    m_we_i,
  input  logic [NREQ-1:0]    m_cab_i,
  input  logic [NREQ-1:0]    m_pref_i,
  input  logic [32*NREQ-1:0] m_adr_i,
  input  logic [32*NREQ-1:0] m_dat_i,
  input  logic [32*NREQ-1:0] m_dat64_i,
  input  logic [4*NREQ-1:0]  m_sel_i,
  output logic [NREQ-1:0]    m_ack_o,
  output logic [NREQ-1:0]    m_rty_o,
  output logic [NREQ-1:0]    m_err_o,
  output logic [31:0]        m_dat_o,
  output logic [31:0]        m_dat64_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic               wbm_cab_o,
  output logic               wbm_pref_o,
  output logic [31:0]        wbm_adr_o,
  output logic [31:0]        wbm_dat_o,
  output logic [31:0]        wbm_dat64_o,
  output logic [3:0]         wbm_sel_o,
  input  logic               wbm_ack_i,
  input  logic               wbm_rty_i,
  input  logic               wbm_err_i,
  input  logic [31:0]        wbm_dat_i,
  input  logic [31:0]        wbm_dat64_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic               timeout_o
);

  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [WDW-1:0]  wdog_q, wdog_d, wdog_inc;

  logic [NREQ-1:0] pick_gnt;
  logic            pick_valid;
  logic            term;
  wb_req_t         sel_req;
  logic [IW-1:0]   sel_idx;

  wb_req_t         req_chain [NREQ+1];
  logic [IW-1:0]   idx_chain [NREQ+1];

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // AND-OR mux of the granted requester's bus and its index
  assign req_chain[0] = '0;
  assign idx_chain[0] = '0;
  for (genvar g = 0; g < NREQ; g++) begin : g_mux
    wb_req_t cand;
    assign cand = '{cyc:   m_cyc_i[g],
                    stb:   m_stb_i[g],
                    we:    m_we_i[g],
                    cab:   m_cab_i[g],
                    pref:  m_pref_i[g],
                    adr:   m_adr_i[32*g +: 32],
                    dat:   m_dat_i[32*g +: 32],
                    dat64: m_dat64_i[32*g +: 32],
                    sel:   m_sel_i[4*g +: 4]};
    assign req_chain[g+1] = req_chain[g] | (gnt_q[g] ? cand : '0);
    assign idx_chain[g+1] = idx_chain[g] | (gnt_q[g] ? IW'(g) : '0);
  end
  assign sel_req = req_chain[NREQ];
  assign sel_idx = idx_chain[NREQ];

  assign term      = wbm_ack_i | wbm_rty_i | wbm_err_i;
  assign m_dat_o   = wbm_dat_i;
  assign m_dat64_o = wbm_dat64_i;
  assign gnt_o     = gnt_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    wdog_d      = '0;
    wdog_inc    = wdog_q + 1'b1;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_cab_o   = 1'b0;
    wbm_pref_o  = 1'b0;
    wbm_adr_o   = '0;
    wbm_dat_o   = '0;
    wbm_dat64_o = '0;
    wbm_sel_o   = '0;
    m_ack_o     = '0;
    m_rty_o     = '0;
    m_err_o     = '0;
    timeout_o   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        wbm_cyc_o   = sel_req.cyc;
        wbm_stb_o   = sel_req.stb;
        wbm_we_o    = sel_req.we;
        wbm_cab_o   = sel_req.cab;
        wbm_pref_o  = sel_req.pref;
        wbm_adr_o   = sel_req.adr;
        wbm_dat_o   = sel_req.dat;
        wbm_dat64_o = sel_req.dat64;
        wbm_sel_o   = sel_req.sel;
        m_ack_o     = gnt_q & {NREQ{wbm_ack_i}};
        m_rty_o     = gnt_q & {NREQ{wbm_rty_i}};
        m_err_o     = gnt_q & {NREQ{wbm_err_i}};
        // A retry releases the grant so other pending requesters go first
        if (!sel_req.cyc || wbm_rty_i) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          last_d  = sel_idx;
        end else if (sel_req.stb && !term) begin
          wdog_d = wdog_inc;
          if (wdog_inc == WDW'(TIMEOUT)) begin
            state_d = ST_TOERR;
            wdog_d  = '0;
          end
        end
      end
      ST_TOERR: begin
        m_err_o   = gnt_q;
        timeout_o = 1'b1;
        state_d   = ST_IDLE;
        gnt_d     = '0;
        last_d    = sel_idx;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

endmodule
